// File: rtl/dmem_pkg.sv
// Shared constants for the pipelined data memory.
package dmem_pkg;
    localparam int MAX_RD_LATENCY = 4;
    localparam int CREDIT_WIDTH   = $clog2(MAX_RD_LATENCY + 1);
endpackage

// File: rtl/dmem_resp_fifo.sv
// Fall-through response FIFO: an entry pushed into an empty FIFO is visible on out_* the same cycle.
// Latency: 0 cycles when empty, otherwise entries leave in push order.
// Backpressure: none upstream; the caller's credits guarantee it never overflows.
module dmem_resp_fifo #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;
    logic             empty, wr_en, rd_en;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign out_vld = !empty || in_vld;
    assign out_dat = empty ? in_dat : mem[rptr];
    // A push that is consumed straight through never occupies an entry.
    assign wr_en   = in_vld && !(empty && out_rdy);
    assign rd_en   = !empty && out_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= ptr_next(wptr);
            if (rd_en) rptr <= ptr_next(rptr);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= in_dat;
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(wr_en && !rd_en && count == CNT_W'(DEPTH)));
        end
    end
endmodule

// File: rtl/dmem_pipe.sv
// Byte-enabled single-port data memory with a pipelined, tagged load-response path.
// Latency: load accepted in cycle N responds in cycle N+RD_LATENCY when nothing older is pending.
// Backpressure: req_ready drops when RD_LATENCY loads are in flight or queued; stages never stall.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4,
    parameter int RD_LATENCY = 1,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [NB_COL-1:0]             req_be,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   req_wdata,
    input  logic [TAG_WIDTH-1:0]          req_tag,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [NB_COL*COL_WIDTH-1:0]   resp_data,
    output logic [TAG_WIDTH-1:0]          resp_tag
);
    localparam int W = NB_COL * COL_WIDTH;

    // Field widths track the module parameters, so the structs live here rather than in the package.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [NB_COL-1:0]     be;
        logic [W-1:0]          wdata;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [W-1:0]         data;
        logic [TAG_WIDTH-1:0] tag;
    } resp_t;

    req_t                    req;
    resp_t                   last_stage, fifo_out;
    logic [CREDIT_WIDTH-1:0] credits;
    logic                    acc, ld_acc, st_acc, resp_hs, in_range;
    logic [W-1:0]            rd_word, last_dat;
    logic [RD_LATENCY-1:0]   st_vld;
    logic [TAG_WIDTH-1:0]    st_tag [RD_LATENCY];

    assign req       = '{addr: req_addr, be: req_be, wdata: req_wdata, tag: req_tag};
    assign req_ready = (credits != '0);
    assign acc       = req_valid && req_ready;
    assign ld_acc    = acc && !req_we;
    assign st_acc    = acc && req_we;
    assign resp_hs   = resp_valid && resp_ready;
    assign in_range  = 32'(req.addr) < DEPTH;

    // One RAM per byte column so each maps onto a plain write-enabled block.
    for (genvar c = 0; c < NB_COL; c++) begin : g_col
        logic [COL_WIDTH-1:0] ram [DEPTH];
        logic [COL_WIDTH-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (st_acc && in_range && req.be[c])
                ram[req.addr] <= req.wdata[c*COL_WIDTH +: COL_WIDTH];
            if (ld_acc)
                rd_q <= in_range ? ram[req.addr] : '0;
        end
        assign rd_word[c*COL_WIDTH +: COL_WIDTH] = rd_q;
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign last_dat = rd_word;
    end else begin : g_latn
        logic [W-1:0] pipe_dat [RD_LATENCY-1];
        always_ff @(posedge clk) begin
            pipe_dat[0] <= rd_word;
            for (int i = 1; i < RD_LATENCY - 1; i++) pipe_dat[i] <= pipe_dat[i-1];
        end
        assign last_dat = pipe_dat[RD_LATENCY-2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_vld  <= '0;
            credits <= CREDIT_WIDTH'(RD_LATENCY);
        end else begin
            st_vld[0] <= ld_acc;
            for (int i = 1; i < RD_LATENCY; i++) st_vld[i] <= st_vld[i-1];
            case ({ld_acc, resp_hs})
                2'b10:   credits <= credits - CREDIT_WIDTH'(1);
                2'b01:   credits <= credits + CREDIT_WIDTH'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ld_acc) st_tag[0] <= req.tag;
        for (int i = 1; i < RD_LATENCY; i++) st_tag[i] <= st_tag[i-1];
    end

    assign last_stage = '{data: last_dat, tag: st_tag[RD_LATENCY-1]};

    dmem_resp_fifo #(
        .DEPTH (RD_LATENCY),
        .WIDTH ($bits(resp_t))
    ) u_resp_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (st_vld[RD_LATENCY-1]),
        .in_dat  (last_stage),
        .out_vld (resp_valid),
        .out_rdy (resp_ready),
        .out_dat (fifo_out)
    );

    assign resp_data = fifo_out.data;
    assign resp_tag  = fifo_out.tag;

    always @(posedge clk) begin
        if (!reset) begin
            assert (RD_LATENCY >= 1 && RD_LATENCY <= MAX_RD_LATENCY);
            assert (!(resp_hs && !ld_acc && credits == CREDIT_WIDTH'(RD_LATENCY)));
        end
    end
endmodule

// File: tb/tb_dmem_pipe.sv
// Directed plus randomized bench for dmem_pipe against a queue-based reference model.
module tb_dmem_pipe;
    localparam int L     = 2;
    localparam int DEPTH = 1000;

    logic        clk, reset;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_be;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_tag;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;

    dmem_pipe #(
        .DEPTH      (DEPTH),
        .COL_WIDTH  (8),
        .NB_COL     (4),
        .RD_LATENCY (L),
        .TAG_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [1024];
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, update the model, advance.
    task automatic op(bit v, bit we, logic [3:0] be, logic [9:0] a, logic [31:0] wd,
                      logic [3:0] tg, bit rr);
        exp_t e;
        bit   exp_rdy, exp_rv;
        req_valid  = v;
        req_we     = we;
        req_be     = be;
        req_addr   = a;
        req_wdata  = wd;
        req_tag    = tg;
        resp_ready = rr;
        #1;
        exp_rdy = (q.size() < L);
        exp_rv  = (q.size() != 0) && (q[0].due <= cyc);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("resp_data", resp_data, q[0].data);
            chk("resp_tag", 32'(resp_tag), 32'(q[0].tag));
            if (rr) void'(q.pop_front());
        end
        if (v && exp_rdy) begin
            if (we) begin
                if (a < 10'(DEPTH))
                    for (int c = 0; c < 4; c++)
                        if (be[c]) ref_mem[a][c*8 +: 8] = wd[c*8 +: 8];
            end else begin
                e.data = (a < 10'(DEPTH)) ? ref_mem[a] : 32'h0;
                e.tag  = tg;
                e.due  = cyc + L;
                q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic st(logic [9:0] a, logic [31:0] wd, logic [3:0] be);
        op(1'b1, 1'b1, be, a, wd, 4'd0, 1'b1);
    endtask

    task automatic ld(logic [9:0] a, logic [3:0] tg, bit rr);
        op(1'b1, 1'b0, 4'h0, a, 32'h0, tg, rr);
    endtask

    task automatic idle(bit rr);
        op(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 4'd0, rr);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        bit rr;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_be     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        idle(1'b1);

        // Store then load, response two cycles after the load.
        st(10'd5, 32'hDEADBEEF, 4'hF);
        ld(10'd5, 4'd3, 1'b1);
        idle(1'b1);
        chk("t1_valid", 32'(resp_valid), 32'd1);
        chk("t1_data", resp_data, 32'hDEADBEEF);
        chk("t1_tag", 32'(resp_tag), 32'd3);
        idle(1'b1);

        // Partial and empty byte enables.
        st(10'd5, 32'h11223344, 4'b0101);
        ld(10'd5, 4'd1, 1'b1);
        idle(1'b1);
        chk("t2_merge", resp_data, 32'hDE22BE44);
        idle(1'b1);
        st(10'd5, 32'hFFFFFFFF, 4'b0000);
        ld(10'd5, 4'd2, 1'b1);
        idle(1'b1);
        chk("t2_be0", resp_data, 32'hDE22BE44);
        idle(1'b1);

        // Credit exhaustion with a stalled consumer.
        st(10'd0, 32'h00000100, 4'hF);
        st(10'd1, 32'h00000101, 4'hF);
        st(10'd2, 32'h00000102, 4'hF);
        ld(10'd0, 4'd1, 1'b0);
        ld(10'd1, 4'd2, 1'b0);
        ld(10'd2, 4'd3, 1'b0);
        ld(10'd2, 4'd3, 1'b0);
        chk("t3_hold_data", resp_data, 32'h00000100);
        chk("t3_hold_tag", 32'(resp_tag), 32'd1);
        chk("t3_blocked", 32'(req_ready), 32'd0);
        idle(1'b1);
        idle(1'b1);
        chk("t3_ready_back", 32'(req_ready), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Accept and pop in the same cycle at one remaining credit.
        ld(10'd5, 4'd4, 1'b0);
        idle(1'b0);
        ld(10'd0, 4'd5, 1'b1);
        chk("t4_ready", 32'(req_ready), 32'd1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset with loads in flight; RAM survives.
        ld(10'd5, 4'd6, 1'b1);
        ld(10'd5, 4'd7, 1'b1);
        do_reset();
        chk("t5_ready", 32'(req_ready), 32'd1);
        chk("t5_no_resp", 32'(resp_valid), 32'd0);
        repeat (4) idle(1'b1);
        ld(10'd5, 4'd8, 1'b1);
        idle(1'b1);
        chk("t5_data", resp_data, 32'hDE22BE44);
        idle(1'b1);

        // Read-after-write back to back.
        st(10'd7, 32'hA5A5A5A5, 4'hF);
        ld(10'd7, 4'd9, 1'b1);
        idle(1'b1);
        chk("t6_valid", 32'(resp_valid), 32'd1);
        chk("t6_raw", resp_data, 32'hA5A5A5A5);
        idle(1'b1);

        // Last legal word and first illegal one.
        st(10'd999, 32'h12345678, 4'hF);
        st(10'd1000, 32'h87654321, 4'hF);
        ld(10'd999, 4'd10, 1'b1);
        ld(10'd1000, 4'd11, 1'b1);
        chk("oor_last_ok", resp_data, 32'h12345678);
        idle(1'b1);
        chk("oor_zero", resp_data, 32'h00000000);
        chk("oor_tag", 32'(resp_tag), 32'd11);
        idle(1'b1);

        // Random alternating traffic with random consumer stalls.
        for (int i = 0; i < 16; i++) st(10'(i), $urandom, 4'hF);
        for (int i = 0; i < 100; i++) begin
            rr = ($urandom_range(3) != 0);
            if (i % 2 == 0)
                op(1'b1, 1'b0, 4'h0, 10'($urandom_range(15)), 32'h0, 4'($urandom_range(15)), rr);
            else
                op(1'b1, 1'b1, 4'($urandom_range(15)), 10'($urandom_range(15)), $urandom, 4'd0, rr);
        end
        repeat (6) idle(1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
